// File: rtl/instr_fetch_seq.sv
// rtl/instr_fetch_seq.sv - halfword fetch sequencer assembling 1..3 halfword instructions
// Issues 16-bit reads, sizes each instruction from hw0's group field, and holds it for the decoder.
module instr_fetch_seq #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned GROUP_HI = 15,
  parameter int unsigned GROUP_LO = 14
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [47:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [1:0]        instr_len,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  typedef enum logic [2:0] {
    FETCH0 = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    HOLD   = 3'd3,
    DRAIN  = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] HW_MASK = ~ADDR_W'(1);
  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC) & HW_MASK;

  state_e            state_q, state_d;
  logic              run_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [15:0]       hw0_q, hw0_d;
  logic [15:0]       hw1_q, hw1_d;
  logic [15:0]       hw2_q, hw2_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [1:0]        len_q, len_d;

  logic [1:0]        idx;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] rpc;
  logic              ack;
  logic [1:0]        new_len;

  function automatic logic [1:0] len_of(input logic [15:0] hw);
    logic [1:0] g;
    g = 2'(hw[GROUP_HI:GROUP_LO]);
    case (g)
      2'd0:    len_of = 2'd1;
      2'd3:    len_of = 2'd3;
      default: len_of = 2'd2;
    endcase
  endfunction

  always_comb begin
    idx = 2'd0;
    if (state_q == FETCH1) idx = 2'd1;
    if (state_q == FETCH2) idx = 2'd2;
  end

  // DRAIN replays the address of the abandoned request until it is acknowledged.
  assign fetch_addr  = pc_q + ADDR_W'({idx, 1'b0});
  assign mem_addr    = (state_q == DRAIN) ? daddr_q : fetch_addr;
  assign mem_req     = run_q && (state_q != HOLD);
  assign ack         = mem_req && mem_ack;
  assign rpc         = redirect_pc & HW_MASK;
  assign new_len     = len_of(mem_rdata);
  assign instr       = {hw0_q, hw1_q, hw2_q};
  assign instr_pc    = ipc_q;
  assign instr_len   = len_q;
  assign instr_valid = (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    daddr_d = daddr_q;
    hw0_d   = hw0_q;
    hw1_d   = hw1_q;
    hw2_d   = hw2_q;
    ipc_d   = ipc_q;
    len_d   = len_q;
    case (state_q)
      FETCH0, FETCH1, FETCH2: begin
        if (redirect) begin
          if (mem_req && !ack) begin
            tgt_d   = rpc;
            daddr_d = mem_addr;
            state_d = DRAIN;
          end else begin
            pc_d    = rpc;
            state_d = FETCH0;
          end
        end else if (ack) begin
          case (state_q)
            FETCH0: begin
              hw0_d   = mem_rdata;
              hw1_d   = 16'h0000;
              hw2_d   = 16'h0000;
              ipc_d   = pc_q;
              len_d   = new_len;
              state_d = (new_len == 2'd1) ? HOLD : FETCH1;
            end
            FETCH1: begin
              hw1_d   = mem_rdata;
              state_d = (len_q == 2'd2) ? HOLD : FETCH2;
            end
            default: begin
              hw2_d   = mem_rdata;
              state_d = HOLD;
            end
          endcase
        end
      end
      HOLD: begin
        // A redirect alongside ready still consumes the instruction; the target wins either way.
        if (redirect) begin
          pc_d    = rpc;
          state_d = FETCH0;
        end else if (instr_ready) begin
          pc_d    = pc_q + ADDR_W'({len_q, 1'b0});
          state_d = FETCH0;
        end
      end
      DRAIN: begin
        if (redirect) tgt_d = rpc;
        if (ack) begin
          pc_d    = redirect ? rpc : tgt_q;
          state_d = FETCH0;
        end
      end
      default: state_d = FETCH0;
    endcase
  end

  // run_q keeps mem_req low for the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH0;
      run_q   <= 1'b0;
      pc_q    <= RST_PC;
      tgt_q   <= '0;
      daddr_q <= '0;
      hw0_q   <= 16'h0000;
      hw1_q   <= 16'h0000;
      hw2_q   <= 16'h0000;
      ipc_q   <= '0;
      len_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      daddr_q <= daddr_d;
      hw0_q   <= hw0_d;
      hw1_q   <= hw1_d;
      hw2_q   <= hw2_d;
      ipc_q   <= ipc_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb/tb_instr_fetch_seq.sv - directed vector bench for instr_fetch_seq
// Cycle table of inputs and expected outputs, then hand sequences for DRAIN corner cases.
module tb_instr_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [47:0] instr;
  logic [31:0] instr_pc;
  logic [1:0]  instr_len;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ack_en;

  logic [15:0] mem [256];
  int checks = 0;
  int errors = 0;

  instr_fetch_seq dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_len(instr_len), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  assign mem_ack   = mem_req & ack_en;
  assign mem_rdata = mem[mem_addr[8:1]];

  typedef struct {
    logic        rst, ack, rdy, red;
    logic [31:0] rpc;
    logic        chk, e_req;
    logic [31:0] e_addr;
    logic        e_valid, chkd;
    logic [47:0] e_instr;
    logic [31:0] e_pc;
    logic [1:0]  e_len;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic r, logic a, logic y, logic d, logic [31:0] p,
                             logic c, logic q, logic [31:0] ad, logic vl,
                             logic cd, logic [47:0] ins, logic [31:0] pc, logic [1:0] ln);
    vec_t t;
    t.rst = r; t.ack = a; t.rdy = y; t.red = d; t.rpc = p;
    t.chk = c; t.e_req = q; t.e_addr = ad; t.e_valid = vl;
    t.chkd = cd; t.e_instr = ins; t.e_pc = pc; t.e_len = ln;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic a, input logic y, input logic d, input logic [31:0] p);
    ack_en = a; instr_ready = y; redirect = d; redirect_pc = p;
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h1234; mem[8'h01] = 16'hC001; mem[8'h02] = 16'hAAAA;
    mem[8'h03] = 16'hBBBB; mem[8'h04] = 16'h5678; mem[8'h05] = 16'h9ABC;
    mem[8'h06] = 16'h8001; mem[8'h07] = 16'h0222; mem[8'h80] = 16'h0F0F;
    mem[8'hFF] = 16'h4321;

    rst = 1'b1; ack_en = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    tbl.push_back(v(1,0,0,0,0,             0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,             1,0,0,0, 1,48'h0,0,0));
    tbl.push_back(v(0,1,1,0,0,             1,1,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,             1,0,0,1, 1,48'h1234_0000_0000,0,1));
    tbl.push_back(v(0,1,0,0,0,             1,1,2,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,             1,1,4,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,             1,1,6,0, 0,0,0,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(0,1,0,0,0,           1,0,0,1, 1,48'hC001_AAAA_BBBB,2,3));
    tbl.push_back(v(0,1,1,0,0,             1,0,0,1, 1,48'hC001_AAAA_BBBB,2,3));
    tbl.push_back(v(0,1,0,0,0,             1,1,32'h8,0, 0,0,0,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(0,0,0,0,0,           1,1,32'hA,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,             1,1,32'hA,0, 0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,             1,0,0,1, 1,48'h5678_9ABC_0000,32'h8,2));
    tbl.push_back(v(0,1,0,0,0,             1,1,32'hC,0, 0,0,0,0));
    tbl.push_back(v(0,0,0,1,32'h0101,      1,1,32'hE,0, 0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,             1,1,32'hE,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,             1,1,32'hE,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,             1,1,32'h100,0, 0,0,0,0));
    tbl.push_back(v(0,1,1,1,32'h2,         1,0,0,1, 1,48'h0F0F_0000_0000,32'h100,1));
    tbl.push_back(v(0,1,0,0,0,             1,1,2,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,             1,1,4,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,             1,1,6,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,1,32'hFFFF_FFFF, 1,0,0,1, 1,48'hC001_AAAA_BBBB,2,3));
    tbl.push_back(v(0,1,0,0,0,             1,1,32'hFFFF_FFFE,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,             1,1,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,             1,0,0,1, 1,48'h4321_1234_0000,32'hFFFF_FFFE,2));
    tbl.push_back(v(0,1,0,0,0,             1,1,2,0, 0,0,0,0));
    tbl.push_back(v(1,0,0,0,0,             1,1,4,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,             1,0,0,0, 1,48'h0,0,0));
    tbl.push_back(v(0,1,0,0,0,             1,1,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,             1,0,0,1, 1,48'h1234_0000_0000,0,1));

    @(negedge clk);
    foreach (tbl[i]) begin
      rst = tbl[i].rst; ack_en = tbl[i].ack; instr_ready = tbl[i].rdy;
      redirect = tbl[i].red; redirect_pc = tbl[i].rpc;
      #1;
      if (tbl[i].chk) begin
        chk($sformatf("row%0d_req", i), 64'(mem_req), 64'(tbl[i].e_req));
        chk($sformatf("row%0d_valid", i), 64'(instr_valid), 64'(tbl[i].e_valid));
        if (tbl[i].e_req || (tbl[i].chkd && !tbl[i].e_valid))
          chk($sformatf("row%0d_addr", i), 64'(mem_addr), 64'(tbl[i].e_addr));
        if (tbl[i].chkd) begin
          chk($sformatf("row%0d_instr", i), 64'(instr), 64'(tbl[i].e_instr));
          chk($sformatf("row%0d_pc", i), 64'(instr_pc), 64'(tbl[i].e_pc));
          chk($sformatf("row%0d_len", i), 64'(instr_len), 64'(tbl[i].e_len));
        end
      end
      @(negedge clk);
    end

    rst = 1'b0;
    cyc(1, 1, 0, 0);             chk("hs_next_addr", 64'(mem_addr), 64'h2);
    cyc(1, 0, 0, 0);             chk("hs_f1_addr", 64'(mem_addr), 64'h4);
    cyc(0, 0, 1, 32'h8);         chk("hs_drain_addr", 64'(mem_addr), 64'h4);
                                 chk("hs_drain_req", 64'(mem_req), 64'h1);
                                 chk("hs_drain_valid", 64'(instr_valid), 64'h0);
    cyc(0, 0, 1, 32'hC);         chk("hs_drain2_addr", 64'(mem_addr), 64'h4);
    cyc(1, 0, 0, 0);             chk("hs_overwrite_tgt", 64'(mem_addr), 64'hC);
    cyc(1, 0, 1, 32'h8);         chk("hs_ack_redirect_addr", 64'(mem_addr), 64'h8);
                                 chk("hs_ack_redirect_valid", 64'(instr_valid), 64'h0);
    begin
      int n;
      n = 0;
      while (!instr_valid && n < 8) begin
        cyc(1, 0, 0, 0);
        n++;
      end
      chk("hs_wait_valid", 64'(instr_valid), 64'h1);
      chk("hs_wait_cycles", 64'(n), 64'd2);
    end
    chk("hs_instr", 64'(instr), 64'h5678_9ABC_0000);
    chk("hs_pc", 64'(instr_pc), 64'h8);
    chk("hs_len", 64'(instr_len), 64'd2);
    cyc(1, 1, 0, 0);             chk("hs_consume_addr", 64'(mem_addr), 64'hC);
    cyc(1, 0, 0, 0);             chk("hs_f1b_addr", 64'(mem_addr), 64'hE);
    cyc(0, 0, 1, 32'h100);       chk("hs_drainb_addr", 64'(mem_addr), 64'hE);
    cyc(1, 0, 1, 32'h2);         chk("hs_drain_ack_redir", 64'(mem_addr), 64'h2);
                                 chk("hs_drain_ack_valid", 64'(instr_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
